// File: rtl/fp_pkg.sv
// Shared types and constants for the FPU add/sub issue front-end.
package fp_pkg;

    // Packed IEEE-754 single-precision value.
    typedef struct packed {
        logic       sign;
        logic [7:0] exp;
        logic [22:0] sig;
    } fp32_t;

    // Issue sequencer states.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } issue_state_t;

    // One queued request: 1 + 4 + 32 + 32 = 69 bits.
    typedef struct packed {
        logic       opcode;
        logic [3:0] tag;
        fp32_t      op1;
        fp32_t      op2;
    } fp_req_t;

    // Datapath error codes; the issue block only captures them.
    localparam logic [2:0] FP_ERR_NONE      = 3'b000;
    localparam logic [2:0] FP_ERR_UNDERFLOW = 3'b001;
    localparam logic [2:0] FP_ERR_OVERFLOW  = 3'b010;
    localparam logic [2:0] FP_ERR_INVALID   = 3'b100;

endpackage

// File: rtl/fp_req_fifo.sv
// Synchronous request FIFO of fp_req_t entries; pointers wrap modulo DEPTH.
module fp_req_fifo
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned PW   = $clog2(DEPTH),
    localparam int unsigned CW   = PW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  fp_req_t       wdata_i,
    input  logic          pop_i,
    output fp_req_t       rdata_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_en, pop_en;
    fp_req_t       mem_q [DEPTH];

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    // Overflow/underflow are dropped here as a last line of defence.
    assign push_en = push_i && !full_o;
    assign pop_en  = pop_i && !empty_o;

    // Next pointer and occupancy.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_en) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_en)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_en, pop_en})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Pointer and count state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push_en) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/fp_addsub_issue.sv
// Issue front-end: queues operand pairs, holds them on the add/sub datapath
// for SETTLE_CYCLES, then returns the captured result in request order.
module fp_addsub_issue
    import fp_pkg::*;
#(
    parameter int unsigned DEPTH         = 2,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_op1,
    input  logic [31:0] req_op2,
    input  logic        req_opcode,
    input  logic [3:0]  req_tag,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_result,
    output logic [2:0]  rsp_error,
    output logic [3:0]  rsp_tag,
    output logic        dp_sign1,
    output logic        dp_sign2,
    output logic [7:0]  dp_exp1,
    output logic [7:0]  dp_exp2,
    output logic [22:0] dp_sig1,
    output logic [22:0] dp_sig2,
    output logic        dp_opcode,
    input  logic [31:0] dp_fp_out,
    input  logic [2:0]  dp_error,
    output logic        busy
);

    localparam int unsigned CW   = $clog2(DEPTH) + 1;
    localparam int unsigned CNTW = $clog2(SETTLE_CYCLES + 1);
    localparam logic [CW-1:0]   DEPTH_C  = CW'(DEPTH);
    localparam logic [CNTW-1:0] SETTLE_C = CNTW'(SETTLE_CYCLES);

    issue_state_t    state_q, state_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    fp_req_t         opreg_q, opreg_d;
    logic            req_ready_q, req_ready_d;
    logic            rsp_valid_q, rsp_valid_d;
    logic [31:0]     rsp_result_q, rsp_result_d;
    logic [2:0]      rsp_error_q, rsp_error_d;
    logic [3:0]      rsp_tag_q, rsp_tag_d;

    fp_req_t         fifo_wdata, fifo_rdata;
    logic            fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [CW-1:0]   fifo_count, count_next;

    assign fifo_wdata = '{opcode: req_opcode, tag: req_tag, op1: req_op1, op2: req_op2};
    assign fifo_push  = req_valid && req_ready_q && !fifo_full;

    fp_req_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .wdata_i (fifo_wdata),
        .pop_i   (fifo_pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // Sequencer next state: pop, settle countdown, capture, response handshake.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        opreg_d      = opreg_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_result_d = rsp_result_q;
        rsp_error_d  = rsp_error_q;
        rsp_tag_d    = rsp_tag_q;
        fifo_pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    opreg_d  = fifo_rdata;
                    cnt_d    = SETTLE_C;
                    state_d  = EXEC;
                end
            end
            EXEC: begin
                cnt_d = cnt_q - CNTW'(1);
                if (cnt_q == CNTW'(1)) begin
                    rsp_result_d = dp_fp_out;
                    rsp_error_d  = dp_error;
                    rsp_tag_d    = opreg_q.tag;
                    rsp_valid_d  = 1'b1;
                    state_d      = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        opreg_d  = fifo_rdata;
                        cnt_d    = SETTLE_C;
                        state_d  = EXEC;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Ready is registered from the post-edge occupancy, so a full FIFO never
    // accepts even when it is being popped on the same edge.
    always_comb begin
        count_next = fifo_count;
        case ({fifo_push, fifo_pop})
            2'b10:   count_next = fifo_count + CW'(1);
            2'b01:   count_next = fifo_count - CW'(1);
            default: count_next = fifo_count;
        endcase
        req_ready_d = (count_next < DEPTH_C);
    end

    // Sequencer, operand and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            opreg_q      <= '0;
            req_ready_q  <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_error_q  <= FP_ERR_NONE;
            rsp_tag_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            opreg_q      <= opreg_d;
            req_ready_q  <= req_ready_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_result_q <= rsp_result_d;
            rsp_error_q  <= rsp_error_d;
            rsp_tag_q    <= rsp_tag_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_result = rsp_result_q;
    assign rsp_error  = rsp_error_q;
    assign rsp_tag    = rsp_tag_q;

    assign dp_sign1  = opreg_q.op1.sign;
    assign dp_exp1   = opreg_q.op1.exp;
    assign dp_sig1   = opreg_q.op1.sig;
    assign dp_sign2  = opreg_q.op2.sign;
    assign dp_exp2   = opreg_q.op2.exp;
    assign dp_sig2   = opreg_q.op2.sig;
    assign dp_opcode = opreg_q.opcode;

    assign busy = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_fp_addsub_issue.sv
// Self-checking bench for fp_addsub_issue: directed vector table, backpressure,
// ordered streaming, mid-operation reset and randomized traffic.
module tb_fp_addsub_issue;

    localparam int unsigned DEPTH  = 2;
    localparam int unsigned SETTLE = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [31:0] req_op1 = '0;
    logic [31:0] req_op2 = '0;
    logic        req_opcode = 1'b0;
    logic [3:0]  req_tag = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [2:0]  rsp_error;
    logic [3:0]  rsp_tag;
    logic        dp_sign1, dp_sign2;
    logic [7:0]  dp_exp1, dp_exp2;
    logic [22:0] dp_sig1, dp_sig2;
    logic        dp_opcode;
    logic [31:0] dp_fp_out;
    logic [2:0]  dp_error;
    logic        busy;

    always #5 clk = ~clk;

    fp_addsub_issue #(
        .DEPTH         (DEPTH),
        .SETTLE_CYCLES (SETTLE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op1    (req_op1),
        .req_op2    (req_op2),
        .req_opcode (req_opcode),
        .req_tag    (req_tag),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_result (rsp_result),
        .rsp_error  (rsp_error),
        .rsp_tag    (rsp_tag),
        .dp_sign1   (dp_sign1),
        .dp_sign2   (dp_sign2),
        .dp_exp1    (dp_exp1),
        .dp_exp2    (dp_exp2),
        .dp_sig1    (dp_sig1),
        .dp_sig2    (dp_sig2),
        .dp_opcode  (dp_opcode),
        .dp_fp_out  (dp_fp_out),
        .dp_error   (dp_error),
        .busy       (busy)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Stand-in datapath: an arbitrary but operand-sensitive function, or a
    // forced outcome for the directed vectors.
    function automatic logic [31:0] dp_mix(input logic [31:0] a, input logic [31:0] b,
                                           input logic op);
        return (a ^ {b[18:0], b[31:19]}) + (op ? 32'h9E37_79B9 : 32'h0000_0001)
               + {b[7:0], a[31:8]};
    endfunction

    function automatic logic [2:0] dp_mix_err(input logic [31:0] a, input logic [31:0] b,
                                              input logic op);
        return {a[31] ^ b[0], a[23] ^ b[31], op ^ a[0] ^ b[23]};
    endfunction

    logic        ovr_en = 1'b0;
    logic [31:0] ovr_res = '0;
    logic [2:0]  ovr_err = '0;

    always_comb begin
        dp_fp_out = '0;
        dp_error  = '0;
        if (ovr_en) begin
            dp_fp_out = ovr_res;
            dp_error  = ovr_err;
        end else begin
            dp_fp_out = dp_mix({dp_sign1, dp_exp1, dp_sig1}, {dp_sign2, dp_exp2, dp_sig2},
                               dp_opcode);
            dp_error  = dp_mix_err({dp_sign1, dp_exp1, dp_sig1}, {dp_sign2, dp_exp2, dp_sig2},
                                   dp_opcode);
        end
    end

    // In-order scoreboard fed by accepted requests, drained by responses.
    typedef struct {
        logic [31:0] res;
        logic [2:0]  err;
        logic [3:0]  tag;
    } rsp_t;

    rsp_t        exp_q[$];
    rsp_t        mon_e;
    int          hs_cyc[$];
    logic [3:0]  hs_tag[$];
    logic        stab_pend = 1'b0;
    logic [31:0] stab_res;
    logic [2:0]  stab_err;
    logic [3:0]  stab_tag;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            stab_pend = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                mon_e.res = ovr_en ? ovr_res : dp_mix(req_op1, req_op2, req_opcode);
                mon_e.err = ovr_en ? ovr_err : dp_mix_err(req_op1, req_op2, req_opcode);
                mon_e.tag = req_tag;
                exp_q.push_back(mon_e);
            end
            if (stab_pend) begin
                chk("rsp_hold_valid", 32'(rsp_valid), 32'd1);
                chk("rsp_hold_result", rsp_result, stab_res);
                chk("rsp_hold_tag", {25'd0, rsp_error, rsp_tag}, {25'd0, stab_err, stab_tag});
            end
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_rsp: got tag %h result %h, expected no response",
                             rsp_tag, rsp_result);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("sb_result", rsp_result, mon_e.res);
                    chk("sb_error", 32'(rsp_error), 32'(mon_e.err));
                    chk("sb_tag", 32'(rsp_tag), 32'(mon_e.tag));
                end
                hs_cyc.push_back(cyc);
                hs_tag.push_back(rsp_tag);
            end
            stab_pend = rsp_valid && !rsp_ready;
            stab_res  = rsp_result;
            stab_err  = rsp_error;
            stab_tag  = rsp_tag;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic opc,
                        input logic [3:0] tg);
        int n = 0;
        req_op1    = a;
        req_op2    = b;
        req_opcode = opc;
        req_tag    = tg;
        req_valid  = 1'b1;
        while (!req_ready && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!req_ready) begin
            chk("send_timeout", 32'(req_ready), 32'd1);
            req_valid = 1'b0;
            return;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic drain();
        int n = 0;
        rsp_ready = 1'b1;
        while ((exp_q.size() != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        chk("drain_done", 32'(exp_q.size() == 0 && !busy), 32'd1);
    endtask

    typedef struct {
        logic [31:0] op1;
        logic [31:0] op2;
        logic        opc;
        logic [3:0]  tag;
        logic [31:0] dp_res;
        logic [2:0]  dp_err;
        logic        s1;
        logic [7:0]  e1;
        logic [22:0] f1;
        logic        s2;
        logic [7:0]  e2;
        logic [22:0] f2;
    } vec_t;

    vec_t        vecs[4];
    logic [31:0] bp_a[4];
    logic [31:0] bp_b[4];
    int          idx;
    logic        acc;
    logic        saw;
    logic        done;

    initial begin
        // 1.0 + 2.0 -> 3.0
        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 1'b0, 4'h5, 32'h4040_0000, 3'b000,
                    1'b0, 8'h7F, 23'h0, 1'b0, 8'h80, 23'h0};
        // -5.0 - 0.5 -> -5.5
        vecs[1] = '{32'hC0A0_0000, 32'h3F00_0000, 1'b1, 4'hA, 32'hC0B0_0000, 3'b000,
                    1'b1, 8'h81, 23'h20_0000, 1'b0, 8'h7E, 23'h0};
        // inf - inf -> qNaN, invalid
        vecs[2] = '{32'h7F80_0000, 32'h7F80_0000, 1'b1, 4'h3, 32'h7FC0_0000, 3'b100,
                    1'b0, 8'hFF, 23'h0, 1'b0, 8'hFF, 23'h0};
        // denormals, underflow code
        vecs[3] = '{32'h0000_0001, 32'h8040_0001, 1'b0, 4'hF, 32'h8040_0000, 3'b001,
                    1'b0, 8'h00, 23'h1, 1'b1, 8'h00, 23'h40_0001};

        // Reset held with a request pending.
        #1 rst_n = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_req_ready", 32'(req_ready), 32'd0);
            chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_dp_exp1", 32'(dp_exp1), 32'd0);
        chk("rst_rsp_result", rsp_result, 32'd0);
        rst_n = 1'b1;
        tick();
        chk("rel_req_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b0;

        // Directed vectors: unpack, latency, capture, hold, handshake.
        for (int v = 0; v < 4; v++) begin
            ovr_en    = 1'b1;
            ovr_res   = vecs[v].dp_res;
            ovr_err   = vecs[v].dp_err;
            rsp_ready = 1'b0;
            send(vecs[v].op1, vecs[v].op2, vecs[v].opc, vecs[v].tag);
            chk("lat_e0", 32'(rsp_valid), 32'd0);
            tick();
            chk("lat_e1", 32'(rsp_valid), 32'd0);
            chk("busy_exec", 32'(busy), 32'd1);
            chk("dp_sign", {30'd0, dp_sign1, dp_sign2}, {30'd0, vecs[v].s1, vecs[v].s2});
            chk("dp_exp", {16'd0, dp_exp1, dp_exp2}, {16'd0, vecs[v].e1, vecs[v].e2});
            chk("dp_sig1", 32'(dp_sig1), 32'(vecs[v].f1));
            chk("dp_sig2", 32'(dp_sig2), 32'(vecs[v].f2));
            chk("dp_opcode", 32'(dp_opcode), 32'(vecs[v].opc));
            tick();
            chk("lat_e2", 32'(rsp_valid), 32'd0);
            tick();
            chk("lat_e3", 32'(rsp_valid), 32'd1);
            chk("vec_result", rsp_result, vecs[v].dp_res);
            chk("vec_error", 32'(rsp_error), 32'(vecs[v].dp_err));
            chk("vec_tag", 32'(rsp_tag), 32'(vecs[v].tag));
            tick();
            chk("vec_hold", 32'(rsp_valid), 32'd1);
            chk("vec_dp_stable", 32'(dp_exp1), 32'(vecs[v].e1));
            rsp_ready = 1'b1;
            tick();
            chk("vec_hs_clear", 32'(rsp_valid), 32'd0);
            chk("vec_idle", 32'(busy), 32'd0);
            rsp_ready = 1'b0;
        end
        ovr_en = 1'b0;

        // Backpressure: with responses stalled only three requests fit.
        for (int i = 0; i < 4; i++) begin
            bp_a[i] = $urandom;
            bp_b[i] = $urandom;
        end
        idx = 0;
        for (int c = 0; c < 12; c++) begin
            if (idx < 4) begin
                req_op1    = bp_a[idx];
                req_op2    = bp_b[idx];
                req_opcode = idx[0];
                req_tag    = 4'(idx + 8);
                req_valid  = 1'b1;
            end else begin
                req_valid = 1'b0;
            end
            acc = req_valid && req_ready;
            tick();
            if (acc) idx++;
        end
        chk("bp_accepted", 32'(idx), 32'd3);
        chk("bp_ready_low", 32'(req_ready), 32'd0);
        chk("bp_rsp_waiting", 32'(rsp_valid), 32'd1);
        rsp_ready = 1'b1;
        tick();
        chk("bp_ready_after_hs", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        drain();

        // Ordered stream with the response side always ready.
        hs_cyc.delete();
        hs_tag.delete();
        rsp_ready = 1'b1;
        for (int t = 1; t <= 4; t++) send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'(t));
        idx = 0;
        while (hs_cyc.size() < 4 && idx < 100) begin
            tick();
            idx++;
        end
        chk("stream_count", 32'(hs_cyc.size()), 32'd4);
        if (hs_cyc.size() >= 4) begin
            for (int k = 0; k < 4; k++) chk("stream_tag", 32'(hs_tag[k]), 32'(k + 1));
            for (int k = 1; k < 4; k++)
                chk("stream_gap", 32'(hs_cyc[k] - hs_cyc[k-1]), 32'(SETTLE + 1));
        end
        drain();

        // Randomized traffic with random response backpressure.
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    for (int g = $urandom_range(0, 2); g > 0; g--) tick();
                    send($urandom, $urandom, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)));
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        drain();

        // Reset while one request executes and another is queued.
        rsp_ready = 1'b1;
        send($urandom, $urandom, 1'b0, 4'h1);
        send($urandom, $urandom, 1'b1, 4'h2);
        #1;
        chk("mid_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("mid_busy", 32'(busy), 32'd0);
        chk("mid_req_ready", 32'(req_ready), 32'd0);
        chk("mid_dp_clear", {8'd0, dp_sig1}, 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        saw = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (rsp_valid || busy) saw = 1'b1;
        end
        chk("mid_no_rsp", 32'(saw), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/fp_addsub_issue.md
# fp_addsub_issue

Sequential front-end for the FPU add/subtract path. It accepts packed IEEE-754 single-precision operand pairs over a valid/ready request channel and buffers them in a small FIFO. It unpacks each pair into sign/exponent/significand fields and drives them into the combinational add/sub datapath as a multicycle path. It then captures the datapath's packed result and 3-bit error code and returns them in order over a valid/ready response channel.

## Interface
- DEPTH, 2: request FIFO entries; power of 2, ≥2.
- SETTLE_CYCLES, 2: cycles the operand registers are held before the datapath output is sampled; ≥1.
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted on an edge where req_valid && req_ready.
- req_op1, req_op2  in  32  packed operands.
- req_opcode  in  1  0 = add, 1 = subtract.
- req_tag  in  4  returned unchanged with the result.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed on an edge where rsp_valid && rsp_ready.
- rsp_result  out  32  packed result.
- rsp_error  out  3  datapath error code, captured unchanged.
- rsp_tag  out  4  tag of the request.
- dp_sign1, dp_sign2  out  1  unpacked signs.
- dp_exp1, dp_exp2  out  8  unpacked exponents.
- dp_sig1, dp_sig2  out  23  unpacked fractions (no hidden bit).
- dp_opcode  out  1  opcode to datapath.
- dp_fp_out  in  32  datapath result.
- dp_error  in  3  datapath error.
- busy  out  1  high when state != IDLE or the FIFO is non-empty.

## Operation
- FIFO entry: {opcode, tag, op1, op2}, 69 bits. Push on request handshake. Pop only by the FSM.
- Operand register: holds the popped entry. All dp_* outputs come straight from this register. The fields are: sign = [31], exp = [30:23], sig = [22:0].
- FSM states:
  - IDLE: if the FIFO is non-empty, pop into the operand register, load settle counter = SETTLE_CYCLES, go to EXEC.
  - EXEC: decrement the counter each cycle. On the edge where the counter == 1, capture dp_fp_out, dp_error and the operand-register tag into the response register, set rsp_valid, go to RESP.
  - RESP: hold all rsp_* outputs stable until the handshake. On the handshake edge, clear rsp_valid. If the FIFO is non-empty, pop and go to EXEC (counter reloaded). Otherwise go to IDLE.
- Responses leave strictly in request order; no reordering or dropping.
- The operand register and dp_* outputs are unchanged from pop until the next pop.
- Push and pop on the same edge: count is unchanged and both take effect.
- req_ready is a flop: next value = (next_count < DEPTH). It never accepts into a full FIFO, even when a pop happens on the same edge.
- The datapath is never interpreted: NaN, overflow and denormal handling all live in the datapath. rsp_error is a pure capture.

## Timing
- Reset (rst_n low, asynchronous): state = IDLE, FIFO count = 0, pointers = 0, req_ready = 0, rsp_valid = 0, rsp_result/rsp_error/rsp_tag = 0, all dp_* = 0, busy = 0.
- req_ready rises on the first clk edge after rst_n deasserts.
- Latency: a request accepted at edge E0 into an idle, empty block gives rsp_valid high after edge E0 + 1 + SETTLE_CYCLES (3 cycles at the default).
- Throughput with rsp_ready held high: one result every SETTLE_CYCLES + 1 cycles.
- Reset mid-operation: in-flight and queued requests are discarded, and no response is produced for them after release.
- FIFO pointers wrap modulo DEPTH. Count is one bit wider than the pointers.

## Structure
- fp_pkg (shared):
  - fp32_t packed struct {sign, exp[7:0], sig[22:0]}.
  - issue_state_t enum {IDLE, EXEC, RESP}.
  - fp_req_t struct for the FIFO entry.
  - FP_ERR_* 3-bit error-code constants.
- Sub-module fp_req_fifo: DEPTH-entry synchronous FIFO of fp_req_t with push, pop, full, empty and count. The FSM, settle counter, operand register and response register stay in the top.

## Test plan
- Reset: hold rst_n low for 3 cycles with req_valid = 1 -> req_ready = 0 and rsp_valid = 0 throughout; req_ready = 1 one edge after release.
- Single add: op1 = 0x3F800000, op2 = 0x40000000, opcode 0, tag 5; model returns 0x40400000, error 0 -> dp_exp1 = 0x7F, dp_exp2 = 0x80, dp_sig2 = 0; rsp_valid 3 cycles after accept with result 0x40400000, tag 5, error 0.
- Backpressure (DEPTH = 2, rsp_ready = 0): offer 4 requests -> 3 accepted (one in the operand register, two in the FIFO); req_ready = 0 until the first response handshake.
- Stream: rsp_ready = 1, tags 1–4 queued -> responses carry tags 1, 2, 3, 4 in order, spaced 3 cycles apart.
- Error capture: subtract with the model driving dp_fp_out = 0x7FC00000 and dp_error = 3'b100 -> rsp_result = 0x7FC00000, rsp_error = 3'b100, and dp_opcode = 1 while in EXEC.
- Reset mid-EXEC: pull rst_n low during EXEC -> rsp_valid = 0 and busy = 0 immediately; no response appears within 10 cycles of release.
